// File: rtl/z3_master_cycle.sv
// z3_master_cycle: Zorro III bus-master cycle engine turning one local request into a
// full FCS/DS/DOE master cycle with DTACK/BERR/timeout handling and read-data capture.
module z3_master_cycle #(
  parameter int ADDR_SETUP = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        bmaster,
  input  logic        req,
  input  logic [31:0] req_addr,
  input  logic        req_read,
  input  logic [1:0]  req_siz,
  input  logic [2:0]  req_fc,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        Z_A_oe,
  output logic [31:0] Z_A,
  output logic [2:0]  Z_FC,
  output logic        Z_READ,
  output logic        Z_FCS_n,
  output logic [3:0]  Z_DS_n,
  output logic        Z_DOE,
  output logic        Z_D_oe,
  output logic [31:0] Z_D_out,
  input  logic [31:0] Z_D_in,
  input  logic        Z_DTACK_n,
  input  logic        Z_BERR_n
);
  typedef enum logic [2:0] {IDLE, ADDR, STRB, DATA, LATCH, REL, WAITN, ABORT} state_t;
  localparam logic [1:0] AS_LAST = 2'(ADDR_SETUP - 1);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      state;
  logic [1:0]  dt_s, be_s, ac;
  logic [7:0]  cnt;
  logic [3:0]  lanes, lane_req;
  logic [2:0]  n_bytes;
  logic        dtack, berr, timeout;
  assign dtack    = !dt_s[1];
  assign berr     = !be_s[1];
  assign busy     = state != IDLE;
  assign timeout  = (TIMEOUT != 0) && (cnt == TO);
  assign n_bytes  = req_siz == 2'b00 ? 3'd4 : {1'b0, req_siz};
  // Leading n lanes of a long, shifted to the byte offset; lanes past D7:0 fall off.
  assign lane_req = ~(~(4'hF >> n_bytes) >> req_addr[1:0]);
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      dt_s <= 2'b11;
      be_s <= 2'b11;
    end else begin
      dt_s <= {dt_s[0], Z_DTACK_n};
      be_s <= {be_s[0], Z_BERR_n};
    end
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state   <= IDLE;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      Z_A_oe  <= 1'b0;
      Z_A     <= '0;
      Z_FC    <= '0;
      Z_READ  <= 1'b1;
      Z_FCS_n <= 1'b1;
      Z_DS_n  <= 4'hF;
      Z_DOE   <= 1'b0;
      Z_D_oe  <= 1'b0;
      Z_D_out <= '0;
      lanes   <= 4'hF;
      ac      <= '0;
      cnt     <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE:
          if (req && bmaster) begin
            state   <= ADDR;
            Z_A     <= req_addr;
            Z_FC    <= req_fc;
            Z_READ  <= req_read;
            Z_D_out <= req_wdata;
            lanes   <= lane_req;
            Z_A_oe  <= 1'b1;
            ac      <= '0;
          end
        ADDR:
          if (!bmaster) state <= ABORT;
          else if (ac == AS_LAST) begin
            state   <= STRB;
            Z_FCS_n <= 1'b0;
          end else ac <= ac + 2'd1;
        STRB:
          if (!bmaster) state <= ABORT;
          else begin
            state  <= DATA;
            Z_DOE  <= 1'b1;
            Z_DS_n <= lanes;
            Z_D_oe <= !Z_READ;
            cnt    <= 8'd1;
          end
        DATA: begin
          cnt <= cnt + 8'd1;
          if (!bmaster || berr || timeout) state <= ABORT;
          else if (dtack) state <= LATCH;
        end
        LATCH:
          if (!bmaster) state <= ABORT;
          else begin
            if (Z_READ) rdata <= Z_D_in;
            ack   <= 1'b1;
            state <= REL;
          end
        REL, ABORT: begin
          err     <= state == ABORT;
          Z_FCS_n <= 1'b1;
          Z_DS_n  <= 4'hF;
          Z_DOE   <= 1'b0;
          Z_D_oe  <= 1'b0;
          state   <= WAITN;
        end
        WAITN:
          if (!dtack && !berr) begin
            state  <= IDLE;
            Z_A_oe <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_z3_master_cycle.sv
// tb_z3_master_cycle: table-driven and randomized checks of z3_master_cycle against a
// transaction-level model of the Zorro III master cycle and a simple bus target.
module tb_z3_master_cycle;
  logic        CLK = 1'b0;
  logic        RESET_n, bmaster, req, req_read;
  logic [31:0] req_addr, req_wdata, Z_D_in;
  logic [1:0]  req_siz;
  logic [2:0]  req_fc;
  logic        Z_DTACK_n, Z_BERR_n;
  logic        ack, err, busy, Z_A_oe, Z_READ, Z_FCS_n, Z_DOE, Z_D_oe;
  logic [31:0] rdata, Z_A, Z_D_out;
  logic [2:0]  Z_FC;
  logic [3:0]  Z_DS_n;
  int          errors = 0, checks = 0;
  logic [31:0] model_rdata = '0;

  z3_master_cycle dut (
    .CLK(CLK), .RESET_n(RESET_n), .bmaster(bmaster), .req(req), .req_addr(req_addr),
    .req_read(req_read), .req_siz(req_siz), .req_fc(req_fc), .req_wdata(req_wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .Z_A_oe(Z_A_oe), .Z_A(Z_A),
    .Z_FC(Z_FC), .Z_READ(Z_READ), .Z_FCS_n(Z_FCS_n), .Z_DS_n(Z_DS_n), .Z_DOE(Z_DOE),
    .Z_D_oe(Z_D_oe), .Z_D_out(Z_D_out), .Z_D_in(Z_D_in), .Z_DTACK_n(Z_DTACK_n),
    .Z_BERR_n(Z_BERR_n));

  always #20 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic [1:0]  siz;
    logic [31:0] wd;
    logic [31:0] dat;
    int          dly;
    bit          be;
    logic [3:0]  exp_ds;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Enabled byte offsets o..o+n-1 clipped to 3; DS_n[3-k] low for each one.
  function automatic logic [3:0] exp_lanes(input logic [31:0] addr, input logic [1:0] siz);
    int n = (siz == 2'b00) ? 4 : int'(siz);
    int o = int'(addr[1:0]);
    logic [3:0] m = 4'hF;
    for (int k = 0; k < 4; k++)
      if (k >= o && k < o + n) m[3-k] = 1'b0;
    return m;
  endfunction

  // Plays the initiator side plus a target that answers dly cycles after DS asserts.
  task automatic run_cycle(input logic [31:0] addr, input logic rd, input logic [1:0] siz,
                           input logic [31:0] wd, input logic [31:0] dat, input int dly,
                           input bit be, input int drop_at, output int n_ack, output int n_err,
                           output int t_done, output logic [3:0] ds, output int fcs_lo,
                           output bit bus_ok);
    int t = 0, ds_t = -1;
    logic [2:0] fc = 3'($urandom);
    @(negedge CLK);
    req_addr = addr; req_read = rd; req_siz = siz; req_wdata = wd; req_fc = fc;
    Z_D_in = dat; bmaster = 1'b1; req = 1'b1;
    n_ack = 0; n_err = 0; t_done = -1; ds = 4'hF; fcs_lo = 0; bus_ok = 1'b1;
    while (t < 400) begin
      @(negedge CLK);
      t++;
      if (busy) req = 1'b0;
      if (drop_at >= 0 && t == drop_at) bmaster = 1'b0;
      if (!Z_FCS_n) fcs_lo++;
      if (Z_DS_n != 4'hF && ds_t < 0) begin ds_t = t; ds = Z_DS_n; end
      if (Z_DOE && (Z_D_oe !== !rd || Z_A !== addr || Z_READ !== rd || Z_FC !== fc ||
                    !Z_A_oe || (!rd && Z_D_out !== wd))) bus_ok = 1'b0;
      if (ack) begin n_ack++; t_done = t; end
      if (err) begin n_err++; t_done = t; end
      if (Z_DS_n == 4'hF) begin Z_DTACK_n = 1'b1; Z_BERR_n = 1'b1; end
      else if (dly >= 0 && t - ds_t >= dly) begin Z_DTACK_n = 1'b0; Z_BERR_n = !be; end
      if (t_done >= 0 && !busy) break;
    end
    req = 1'b0;
    bmaster = 1'b1;
  endtask

  // Expected outcome: drop -> err 2 cycles later; silence -> err 256 cycles after DS;
  // otherwise a response reaches ack/err 4 cycles after the target drives it.
  task automatic check_txn(input string name, input logic [31:0] addr, input logic rd,
                           input logic [1:0] siz, input logic [31:0] wd, input logic [31:0] dat,
                           input int dly, input bit be, input int drop_at, input logic [3:0] exp_ds);
    int n_ack, n_err, t_done, fcs_lo, exp_t;
    logic [3:0] ds;
    bit bus_ok, exp_err;
    run_cycle(addr, rd, siz, wd, dat, dly, be, drop_at, n_ack, n_err, t_done, ds, fcs_lo, bus_ok);
    exp_err = drop_at >= 0 || dly < 0 || be;
    exp_t = drop_at >= 0 ? drop_at + 2 : dly < 0 ? 3 + 256 : 3 + dly + 4;
    if (!exp_err && rd) model_rdata = dat;
    if (drop_at < 0) chk({name, " ds_n"}, 32'(ds), 32'(exp_ds));
    chk({name, " ack count"}, n_ack, exp_err ? 0 : 1);
    chk({name, " err count"}, n_err, exp_err ? 1 : 0);
    chk({name, " done cycle"}, t_done, exp_t);
    chk({name, " rdata"}, rdata, model_rdata);
    chk({name, " bus fields"}, 32'(bus_ok), 32'(1));
    if (!exp_err) chk({name, " fcs held >=3"}, 32'(fcs_lo >= 3), 32'(1));
    chk({name, " released"}, {Z_FCS_n, Z_DS_n, Z_DOE, Z_D_oe, Z_A_oe, busy},
        {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    vec_t vecs[7];
    RESET_n = 1'b0; bmaster = 1'b1; req = 1'b0; req_addr = '0; req_read = 1'b1;
    req_siz = '0; req_fc = '0; req_wdata = '0; Z_D_in = '0; Z_DTACK_n = 1'b1; Z_BERR_n = 1'b1;
    vecs[0] = '{"rd long@0",    32'h4000_0000, 1'b1, 2'b00, 32'h0,         32'hCAFE_F00D, 3, 1'b0, 4'b0000};
    vecs[1] = '{"wr word@2",    32'h4000_0002, 1'b0, 2'b10, 32'h1234_ABCD, 32'h0,         1, 1'b0, 4'b1100};
    vecs[2] = '{"rd byte@3",    32'h4000_0003, 1'b1, 2'b01, 32'h0,         32'h0000_00A5, 0, 1'b0, 4'b1110};
    vecs[3] = '{"rd long@1",    32'h4000_0001, 1'b1, 2'b00, 32'h0,         32'h1122_3344, 2, 1'b0, 4'b1000};
    vecs[4] = '{"rd 3byte@0",   32'h4000_0004, 1'b1, 2'b11, 32'h0,         32'h5566_7788, 1, 1'b0, 4'b0001};
    vecs[5] = '{"berr+dtack",   32'h4000_0010, 1'b1, 2'b10, 32'h0,         32'hDEAD_BEEF, 2, 1'b1, 4'b0011};
    vecs[6] = '{"wr byte@1",    32'h4000_0021, 1'b0, 2'b01, 32'hA1B2_C3D4, 32'h0,         0, 1'b0, 4'b1011};
    repeat (3) @(negedge CLK);
    chk("reset outputs", {ack, err, busy, Z_A_oe, Z_D_oe, Z_DOE, Z_FCS_n, Z_DS_n, Z_READ, Z_FC},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 3'd0});
    chk("reset rdata", rdata, 32'h0);
    chk("reset Z_A", Z_A, 32'h0);
    chk("reset Z_D_out", Z_D_out, 32'h0);
    RESET_n = 1'b1;
    @(negedge CLK);
    foreach (vecs[i])
      check_txn(vecs[i].name, vecs[i].addr, vecs[i].rd, vecs[i].siz, vecs[i].wd, vecs[i].dat,
                vecs[i].dly, vecs[i].be, -1, vecs[i].exp_ds);
    check_txn("timeout", 32'h4000_0100, 1'b1, 2'b00, 32'h0, 32'h0BAD_0BAD, -1, 1'b0, -1, 4'b0000);
    check_txn("grant lost", 32'h4000_0200, 1'b1, 2'b00, 32'h0, 32'h0BAD_0BAD, -1, 1'b0, 5, 4'b0000);
    @(negedge CLK);
    bmaster = 1'b0; req = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("no grant busy", {busy, Z_A_oe}, 2'b00);
    end
    req = 1'b0; bmaster = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a = {2'b01, 30'($urandom)};
      logic [1:0]  s = 2'($urandom);
      logic        r = 1'($urandom);
      check_txn("random", a, r, s, $urandom, $urandom, int'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0), -1, exp_lanes(a, s));
    end
    begin
      int w = 0;
      @(negedge CLK);
      req_addr = 32'h4000_0300; req_read = 1'b1; req_siz = 2'b00; req = 1'b1;
      while (!Z_DOE && w < 20) begin @(negedge CLK); w++; if (busy) req = 1'b0; end
      req = 1'b0;
      chk("reset mid-cycle reached DATA", 32'(Z_DOE), 32'(1));
      #5 RESET_n = 1'b0;
      #1 chk("reset mid-cycle strobes", {Z_FCS_n, Z_DS_n, Z_DOE, Z_D_oe, busy},
             {1'b1, 4'hF, 1'b0, 1'b0, 1'b0});
      model_rdata = '0;
      w = 0;
      repeat (3) @(negedge CLK) if (ack || err) w++;
      chk("reset mid-cycle no response", w, 0);
      RESET_n = 1'b1;
      @(negedge CLK);
      check_txn("read after reset", 32'h4000_0400, 1'b1, 2'b00, 32'h0, 32'h600D_CAFE, 0, 1'b0,
                -1, 4'b0000);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
